// File: rtl/alu_decode_stage.sv
// RV32I decode stage: decodes instr into ALU/control fields and registers the
// result one clock later, with flush/stall/bubble handling on the output reg.
module alu_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [4:0]  arith_control,
  output logic [1:0]  src_a_sel,
  output logic        src_b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic [2:0]  branch_type,
  output logic        illegal,
  output logic [31:0] pc_out
);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLT  = 5'd5,
    ALU_SLTU = 5'd6,
    ALU_SLL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SRL  = 5'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  typedef struct packed {
    alu_op_e     arith;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [2:0]  branch_type;
    logic        illegal;
  } dec_t;

  dec_t        d;
  dec_t        q;
  logic        valid_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] pc_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Every immediate format sign-extends from instr[31]; shift amounts are raw.
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  assign in_ready = ~stall;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    d       = '0;
    d.arith = ALU_ADD;
    if (instr[1:0] != 2'b11) begin
      d.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          d.reg_write = 1'b1;
          case ({funct7, funct3})
            10'b0000000_000: d.arith = ALU_ADD;
            10'b0000000_001: d.arith = ALU_SLL;
            10'b0000000_010: d.arith = ALU_SLT;
            10'b0000000_011: d.arith = ALU_SLTU;
            10'b0000000_100: d.arith = ALU_XOR;
            10'b0000000_101: d.arith = ALU_SRL;
            10'b0000000_110: d.arith = ALU_OR;
            10'b0000000_111: d.arith = ALU_AND;
            10'b0100000_000: d.arith = ALU_SUB;
            10'b0100000_101: d.arith = ALU_SRA;
            default:         d.illegal = 1'b1;
          endcase
        end
        OPC_OP_IMM: begin
          d.reg_write = 1'b1;
          d.b_sel     = 1'b1;
          d.imm       = imm_i;
          case (funct3)
            3'b000: d.arith = ALU_ADD;
            3'b010: d.arith = ALU_SLT;
            3'b011: d.arith = ALU_SLTU;
            3'b100: d.arith = ALU_XOR;
            3'b110: d.arith = ALU_OR;
            3'b111: d.arith = ALU_AND;
            3'b001: begin
              d.imm = imm_sh;
              if (funct7 == 7'b0000000) d.arith = ALU_SLL;
              else                      d.illegal = 1'b1;
            end
            default: begin
              d.imm = imm_sh;
              if      (funct7 == 7'b0000000) d.arith = ALU_SRL;
              else if (funct7 == 7'b0100000) d.arith = ALU_SRA;
              else                           d.illegal = 1'b1;
            end
          endcase
        end
        OPC_LOAD: begin
          d.b_sel     = 1'b1;
          d.imm       = imm_i;
          d.mem_read  = 1'b1;
          d.reg_write = 1'b1;
        end
        OPC_STORE: begin
          d.b_sel     = 1'b1;
          d.imm       = imm_s;
          d.mem_write = 1'b1;
        end
        OPC_BRANCH: begin
          d.arith       = ALU_SUB;
          d.imm         = imm_b;
          d.branch      = 1'b1;
          d.branch_type = funct3;
          if (funct3 == 3'b010 || funct3 == 3'b011) d.illegal = 1'b1;
        end
        OPC_LUI: begin
          d.a_sel     = SRC_A_ZERO;
          d.b_sel     = 1'b1;
          d.imm       = imm_u;
          d.reg_write = 1'b1;
        end
        OPC_AUIPC: begin
          d.a_sel     = SRC_A_PC;
          d.b_sel     = 1'b1;
          d.imm       = imm_u;
          d.reg_write = 1'b1;
        end
        OPC_JAL: begin
          d.a_sel     = SRC_A_PC;
          d.b_sel     = 1'b1;
          d.imm       = imm_j;
          d.jump      = 1'b1;
          d.reg_write = 1'b1;
        end
        OPC_JALR: begin
          d.a_sel     = SRC_A_RS1;
          d.b_sel     = 1'b1;
          d.imm       = imm_i;
          d.jump      = 1'b1;
          d.reg_write = 1'b1;
          if (funct3 != 3'b000) d.illegal = 1'b1;
        end
        default: d.illegal = 1'b1;
      endcase
    end
    // An undecodable word carries only the illegal flag downstream.
    if (d.illegal) begin
      d         = '0;
      d.arith   = ALU_ADD;
      d.illegal = 1'b1;
    end
    // Writes to x0 are architecturally discarded.
    if (instr[11:7] == 5'd0) d.reg_write = 1'b0;
  end

  // Output register: reset, then flush, then stall, then capture or bubble.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all fields change together at the edge.
    if (reset) begin
      q       <= '0;
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      valid_q     <= 1'b0;
      q.reg_write <= 1'b0;
      q.mem_read  <= 1'b0;
      q.mem_write <= 1'b0;
      q.branch    <= 1'b0;
      q.jump      <= 1'b0;
      q.illegal   <= 1'b0;
    end else if (!stall) begin
      q       <= d;
      valid_q <= 1'b1;
      rs1_q   <= instr[19:15];
      rs2_q   <= instr[24:20];
      rd_q    <= instr[11:7];
      pc_q    <= pc;
    end
  end

  assign out_valid     = valid_q;
  assign arith_control = q.arith;
  assign src_a_sel     = q.a_sel;
  assign src_b_sel     = q.b_sel;
  assign imm           = q.imm;
  assign reg_write     = q.reg_write;
  assign mem_read      = q.mem_read;
  assign mem_write     = q.mem_write;
  assign branch        = q.branch;
  assign jump          = q.jump;
  assign branch_type   = q.branch_type;
  assign illegal       = q.illegal;
  assign rs1           = rs1_q;
  assign rs2           = rs2_q;
  assign rd            = rd_q;
  assign pc_out        = pc_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: a decode vector table plus hand-written
// reset, stall, flush and bubble sequences.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic        in_ready, out_valid, src_b_sel;
  logic [31:0] instr, pc, imm, pc_out;
  logic [4:0]  arith_control, rs1, rs2, rd;
  logic [1:0]  src_a_sel;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [2:0]  branch_type;

  int errors = 0;
  int checks = 0;

  alu_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .stall(stall), .flush(flush),
    .out_valid(out_valid), .arith_control(arith_control),
    .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .branch_type(branch_type),
    .illegal(illegal), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  arith;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic        rw, mr, mw, br, jp;
    logic [2:0]  bt;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [31:0] ins, logic [4:0] arith,
                              logic [1:0] a_sel, logic b_sel, logic [31:0] im,
                              logic rw, logic mr, logic mw, logic br, logic jp,
                              logic [2:0] bt, logic ill);
    vec_t v;
    v.name = name; v.instr = ins; v.arith = arith; v.a_sel = a_sel; v.b_sel = b_sel;
    v.imm = im; v.rw = rw; v.mr = mr; v.mw = mw; v.br = br; v.jp = jp;
    v.bt = bt; v.ill = ill;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;

    // name, instr, arith, a_sel, b_sel, imm, rw, mr, mw, br, jp, bt, ill
    vecs.push_back(mk("sub",       32'h40B50533, 5'd1, 2'd0, 1'b0, 32'h0,        1,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("srai",      32'h40335293, 5'd8, 2'd0, 1'b1, 32'h3,        1,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("lui",       32'h123450B7, 5'd0, 2'd2, 1'b1, 32'h12345000, 1,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("addi_x0",   32'h00100013, 5'd0, 2'd0, 1'b1, 32'h1,        0,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("all_ones",  32'hFFFFFFFF, 5'd0, 2'd0, 1'b0, 32'h0,        0,0,0,0,0, 3'd0, 1));
    vecs.push_back(mk("add",       32'h002081B3, 5'd0, 2'd0, 1'b0, 32'h0,        1,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("sltu",      32'h0062B233, 5'd6, 2'd0, 1'b0, 32'h0,        1,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("op_bad_f7", 32'h40629233, 5'd0, 2'd0, 1'b0, 32'h0,        0,0,0,0,0, 3'd0, 1));
    vecs.push_back(mk("lw",        32'hFFC12383, 5'd0, 2'd0, 1'b1, 32'hFFFFFFFC, 1,1,0,0,0, 3'd0, 0));
    vecs.push_back(mk("sw",        32'h00512423, 5'd0, 2'd0, 1'b1, 32'h8,        0,0,1,0,0, 3'd0, 0));
    vecs.push_back(mk("beq",       32'hFE208CE3, 5'd1, 2'd0, 1'b0, 32'hFFFFFFF8, 0,0,0,1,0, 3'd0, 0));
    vecs.push_back(mk("bne",       32'hFE209CE3, 5'd1, 2'd0, 1'b0, 32'hFFFFFFF8, 0,0,0,1,0, 3'd1, 0));
    vecs.push_back(mk("br_f3_010", 32'hFE20ACE3, 5'd0, 2'd0, 1'b0, 32'h0,        0,0,0,0,0, 3'd0, 1));
    vecs.push_back(mk("jal",       32'h001000EF, 5'd0, 2'd1, 1'b1, 32'h800,      1,0,0,0,1, 3'd0, 0));
    vecs.push_back(mk("jalr",      32'h004280E7, 5'd0, 2'd0, 1'b1, 32'h4,        1,0,0,0,1, 3'd0, 0));
    vecs.push_back(mk("jalr_f3",   32'h004290E7, 5'd0, 2'd0, 1'b0, 32'h0,        0,0,0,0,0, 3'd0, 1));
    vecs.push_back(mk("auipc",     32'h00001117, 5'd0, 2'd1, 1'b1, 32'h1000,     1,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("slli_bad",  32'h02009093, 5'd0, 2'd0, 1'b0, 32'h0,        0,0,0,0,0, 3'd0, 1));
    vecs.push_back(mk("addi_b30",  32'h40000093, 5'd0, 2'd0, 1'b1, 32'h400,      1,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("low_bits",  32'h00000031, 5'd0, 2'd0, 1'b0, 32'h0,        0,0,0,0,0, 3'd0, 1));
    vecs.push_back(mk("xori_m1",   32'hFFF1C193, 5'd4, 2'd0, 1'b1, 32'hFFFFFFFF, 1,0,0,0,0, 3'd0, 0));
    vecs.push_back(mk("srli_31",   32'h01F15093, 5'd9, 2'd0, 1'b1, 32'h1F,       1,0,0,0,0, 3'd0, 0));

    // Reset with live input and stall low: everything clears.
    reset = 1'b1; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    instr = 32'h40B50533; pc = 32'hDEAD_BEE0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_arith", arith_control, 0);
    check("rst_illegal", illegal, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_imm", imm, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_rd", rd, 0);
    check("rst_in_ready", in_ready, 1);
    stall = 1'b1;
    #1;
    check("rst_in_ready_stall", in_ready, 0);
    stall = 1'b0;

    // Release with no input: stays empty.
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check("rel_out_valid", out_valid, 0);
    check("rel_arith", arith_control, 0);
    check("rel_illegal", illegal, 0);
    check("rel_in_ready", in_ready, 1);

    // Decode table, one instruction per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      instr = vecs[i].instr; pc = 32'h1000 + 32'(i * 4); in_valid = 1'b1;
      w = vecs[i].instr;
      tick();
      check({vecs[i].name, ".out_valid"}, out_valid, 1);
      check({vecs[i].name, ".illegal"}, illegal, vecs[i].ill);
      check({vecs[i].name, ".arith"}, arith_control, vecs[i].arith);
      if (!vecs[i].ill) begin
        check({vecs[i].name, ".src_a_sel"}, src_a_sel, vecs[i].a_sel);
        check({vecs[i].name, ".src_b_sel"}, src_b_sel, vecs[i].b_sel);
        check({vecs[i].name, ".imm"}, imm, vecs[i].imm);
      end
      check({vecs[i].name, ".reg_write"}, reg_write, vecs[i].rw);
      check({vecs[i].name, ".mem_read"}, mem_read, vecs[i].mr);
      check({vecs[i].name, ".mem_write"}, mem_write, vecs[i].mw);
      check({vecs[i].name, ".branch"}, branch, vecs[i].br);
      check({vecs[i].name, ".jump"}, jump, vecs[i].jp);
      check({vecs[i].name, ".branch_type"}, branch_type, vecs[i].bt);
      check({vecs[i].name, ".rs1"}, rs1, w[19:15]);
      check({vecs[i].name, ".rs2"}, rs2, w[24:20]);
      check({vecs[i].name, ".rd"}, rd, w[11:7]);
      check({vecs[i].name, ".pc_out"}, pc_out, 32'h1000 + 32'(i * 4));
    end

    // Bubble: no input and no stall drops valid and enables.
    in_valid = 1'b0;
    tick();
    check("bubble_out_valid", out_valid, 0);
    check("bubble_reg_write", reg_write, 0);

    // Capture sub, then stall three cycles while the input keeps changing.
    instr = 32'h40B50533; pc = 32'h0000_2000; in_valid = 1'b1;
    tick();
    check("cap_out_valid", out_valid, 1);
    check("cap_arith", arith_control, 1);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      instr = (c == 0) ? 32'h123450B7 : (c == 1) ? 32'hFFFFFFFF : 32'h00512423;
      pc = 32'h0000_3000 + 32'(c * 4);
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_arith", arith_control, 1);
      check("stall_rd", rd, 10);
      check("stall_reg_write", reg_write, 1);
      check("stall_illegal", illegal, 0);
      check("stall_src_a", src_a_sel, 0);
      check("stall_pc_out", pc_out, 32'h0000_2000);
    end

    // Flush wins over stall.
    flush = 1'b1;
    tick();
    check("flush_stall_out_valid", out_valid, 0);
    check("flush_stall_reg_write", reg_write, 0);
    check("flush_stall_mem_write", mem_write, 0);

    // Flush alone with a live input also squashes.
    stall = 1'b0; flush = 1'b1; in_valid = 1'b1; instr = 32'h001000EF;
    tick();
    check("flush_out_valid", out_valid, 0);
    check("flush_jump", jump, 0);
    flush = 1'b0;
    tick();
    check("post_flush_jump", jump, 1);
    check("post_flush_out_valid", out_valid, 1);

    // Reset asserted mid-stall clears everything.
    stall = 1'b1; instr = 32'h40B50533;
    tick();
    check("pre_rst_jump_held", jump, 1);
    reset = 1'b1;
    tick();
    check("rst_stall_out_valid", out_valid, 0);
    check("rst_stall_jump", jump, 0);
    check("rst_stall_imm", imm, 0);
    check("rst_stall_src_a", src_a_sel, 0);
    check("rst_stall_pc_out", pc_out, 0);
    check("rst_stall_in_ready", in_ready, 0);
    reset = 1'b0; stall = 1'b0; in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
